// File: rtl/spi_master_cfg.sv
// Parametrised 4-wire SPI master: one {rw, addr, data} frame per start pulse, MSB first.
// Define SPI_MASTER_CFG_LOOPBACK_EN to enable the internal MOSI->MISO loopback.
module spi_master_cfg #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 20,
    parameter int unsigned CLK_DIV = 4,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrdata,
    input  logic              loopback,
    output logic              busy,
    output logic              done,
    output logic              rd_ok,
    output logic [DATA_W-1:0] rddata,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W     = $clog2(2 * FRAME_LEN);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * FRAME_LEN - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    state_e               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] tx_q, tx_d;
    logic [DATA_W-1:0]    rx_q, rx_d;
    logic [DATA_W-1:0]    rddata_q, rddata_d;
    logic                 rw_q, rw_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 done_q, done_d;
    logic                 rd_ok_q, rd_ok_d;
    logic                 miso_int;
    logic                 div_end;
    logic                 sample_now;

`ifdef SPI_MASTER_CFG_LOOPBACK_EN
    logic loop_q;

    // Loopback select is frozen for the whole frame, including the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            loop_q <= 1'b0;
        end else if (state_q == StIdle) begin
            loop_q <= loopback;
        end
    end

    assign miso_int = loop_q ? mosi_q : miso;
`else
    logic unused_loopback;
    assign unused_loopback = loopback;
    assign miso_int        = miso;
`endif

    assign div_end = (div_q == DIV_LAST);
    // Even half-periods end in a leading edge; CPHA moves sampling to the trailing one.
    assign sample_now = ~cnt_q[0] ^ CPHA;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q + DIV_W'(1);
        cnt_d    = cnt_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rddata_d = rddata_q;
        rw_d     = rw_q;
        sclk_d   = CPOL;
        mosi_d   = mosi_q;
        done_d   = 1'b0;
        rd_ok_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                cnt_d = '0;
                if (start) begin
                    state_d = StSetup;
                    rw_d    = rw;
                    tx_d    = {rw, addr, (rw ? {DATA_W{1'b0}} : wrdata)};
                    mosi_d  = CPHA ? 1'b0 : rw;
                end
            end
            StSetup: begin
                if (div_end) begin
                    state_d = StShift;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                sclk_d = sclk_q;
                if (div_end) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (sample_now) begin
                        rx_d = (rx_q << 1) | DATA_W'(miso_int);
                    end else begin
                        // CPHA=0 already shows bit 0, so the next bit is one below the MSB.
                        mosi_d = CPHA ? tx_q[FRAME_LEN-1] : tx_q[FRAME_LEN-2];
                        tx_d   = tx_q << 1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end
                end
            end
            StHold: begin
                if (div_end) begin
                    state_d = StGap;
                    div_d   = '0;
                    done_d  = 1'b1;
                    rd_ok_d = rw_q;
                    mosi_d  = 1'b0;
                    if (rw_q) begin
                        rddata_d = rx_q;
                    end
                end
            end
            StGap: begin
                if (div_end) begin
                    state_d = StIdle;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            cnt_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rddata_q <= '0;
            rw_q     <= 1'b0;
            sclk_q   <= CPOL;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_ok_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rddata_q <= rddata_d;
            rw_q     <= rw_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            done_q   <= done_d;
            rd_ok_q  <= rd_ok_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign cs_n   = !((state_q == StSetup) || (state_q == StShift) || (state_q == StHold));
    assign sclk   = sclk_q;
    assign mosi   = mosi_q;
    assign done   = done_q;
    assign rd_ok  = rd_ok_q;
    assign rddata = rddata_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: default mode-0 instance plus a CPOL=1/CPHA=1 narrow instance,
// each with a behavioural SPI slave that records MOSI and replies on MISO.
module tb_spi_master_cfg;

    localparam int LAT0 = 1 + 2 * 4 + 2 * 4 * (1 + 4 + 20);
    localparam int LAT1 = 1 + 2 * 1 + 2 * 1 * (1 + 7 + 8);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    logic        start0 = 1'b0, rw0 = 1'b0, loopback0 = 1'b0, miso0 = 1'b0;
    logic [3:0]  addr0 = '0;
    logic [19:0] wrdata0 = '0;
    logic        busy0, done0, rd_ok0, sclk0, cs_n0, mosi0;
    logic [19:0] rddata0;

    logic        start1 = 1'b0, rw1 = 1'b0, miso1 = 1'b0;
    logic [6:0]  addr1 = '0;
    logic [7:0]  wrdata1 = '0;
    logic        busy1, done1, rd_ok1, sclk1, cs_n1, mosi1;
    logic [7:0]  rddata1;

    int          n_pass = 0;
    int          n_total = 0;
    logic [19:0] model_rd0 = '0;
    logic [7:0]  model_rd1 = '0;

    spi_master_cfg dut0 (
        .clk(clk), .rst(rst), .start(start0), .rw(rw0), .addr(addr0), .wrdata(wrdata0),
        .loopback(loopback0), .busy(busy0), .done(done0), .rd_ok(rd_ok0), .rddata(rddata0),
        .sclk(sclk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0)
    );

    spi_master_cfg #(
        .ADDR_W(7), .DATA_W(8), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rw(rw1), .addr(addr1), .wrdata(wrdata1),
        .loopback(1'b0), .busy(busy1), .done(done1), .rd_ok(rd_ok1), .rddata(rddata1),
        .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
    );

    // Mode-0 slave: first bit valid at CS fall, capture on rising SCLK, advance on falling.
    logic [24:0] s0_resp = '0, s0_sh = '0, s0_cap = '0;
    logic        s0_psclk = 1'b0, s0_pcs = 1'b1, s0_force = 1'b0;
    always @(negedge clk) begin
        if (s0_pcs && !cs_n0) begin
            s0_cap <= '0;
            miso0  <= s0_resp[24];
            s0_sh  <= s0_resp << 1;
        end else if (!cs_n0 && sclk0 != s0_psclk) begin
            if (sclk0) begin
                s0_cap <= {s0_cap[23:0], mosi0};
            end else begin
                miso0 <= s0_sh[24];
                s0_sh <= s0_sh << 1;
            end
        end
        if (s0_force) miso0 <= 1'b1;
        s0_psclk <= sclk0;
        s0_pcs   <= cs_n0;
    end

    // Mode-3 slave: drive on falling (leading) SCLK, capture on rising (trailing).
    logic [15:0] s1_resp = '0, s1_sh = '0, s1_cap = '0;
    logic        s1_psclk = 1'b1, s1_pcs = 1'b1;
    always @(negedge clk) begin
        if (s1_pcs && !cs_n1) begin
            s1_cap <= '0;
            s1_sh  <= s1_resp;
        end else if (!cs_n1 && sclk1 != s1_psclk) begin
            if (!sclk1) begin
                miso1 <= s1_sh[15];
                s1_sh <= s1_sh << 1;
            end else begin
                s1_cap <= {s1_cap[14:0], mosi1};
            end
        end
        s1_psclk <= sclk1;
        s1_pcs   <= cs_n1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic frame0(input logic r, input logic [3:0] a, input logic [19:0] d,
                          input logic [19:0] resp);
        int          lat;
        bit          bad_rdok;
        logic [24:0] exp_frame;
        lat      = -1;
        bad_rdok = 1'b0;
        s0_resp  = {5'($urandom), resp};
        rw0 = r; addr0 = a; wrdata0 = d; start0 = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start0 = 1'b0;
                chk("cs_n0 low at T+1", cs_n0, 1'b0);
                chk("busy0 at T+1", busy0, 1'b1);
                rw0 = 1'($urandom); addr0 = 4'($urandom); wrdata0 = 20'($urandom);
            end
            if (n == 5) start0 = 1'b1;
            if (n == 6) start0 = 1'b0;
            if (rd_ok0 && !done0) bad_rdok = 1'b1;
            if (done0) begin
                lat = n;
                break;
            end
        end
        if (r) model_rd0 = resp;
        exp_frame = {r, a, (r ? 20'h0 : d)};
        chk("latency0", lat, LAT0);
        chk("cs_n0 at done", cs_n0, 1'b1);
        chk("busy0 at done", busy0, 1'b1);
        chk("rd_ok0 at done", rd_ok0, r);
        chk("stray rd_ok0", bad_rdok, 1'b0);
        chk("rddata0", rddata0, model_rd0);
        chk("mosi0 frame", s0_cap, exp_frame);
        start0 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            chk("cs_n0 in gap", cs_n0, 1'b1);
            chk("busy0 in gap", busy0, k < 4);
            chk("done0 width", done0, 1'b0);
        end
        chk("rddata0 held", rddata0, model_rd0);
    endtask

    task automatic frame1(input logic r, input logic [6:0] a, input logic [7:0] d,
                          input logic [7:0] resp);
        int          lat;
        logic [15:0] exp_frame;
        lat     = -1;
        s1_resp = {8'($urandom), resp};
        rw1 = r; addr1 = a; wrdata1 = d; start1 = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                start1 = 1'b0;
                chk("cs_n1 low at T+1", cs_n1, 1'b0);
                chk("sclk1 idle high in setup", sclk1, 1'b1);
                rw1 = 1'($urandom); addr1 = 7'($urandom); wrdata1 = 8'($urandom);
            end
            if (n == 3) start1 = 1'b1;
            if (n == 4) start1 = 1'b0;
            if (done1) begin
                lat = n;
                break;
            end
        end
        if (r) model_rd1 = resp;
        exp_frame = {r, a, (r ? 8'h0 : d)};
        chk("latency1", lat, LAT1);
        chk("sclk1 at done", sclk1, 1'b1);
        chk("rd_ok1 at done", rd_ok1, r);
        chk("rddata1", rddata1, model_rd1);
        chk("mosi1 frame", s1_cap, exp_frame);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("busy1 after gap", busy1, 1'b0);
        chk("cs_n1 after gap", cs_n1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy0", busy0, 1'b0);
        chk("reset done0", done0, 1'b0);
        chk("reset rd_ok0", rd_ok0, 1'b0);
        chk("reset rddata0", rddata0, 20'h0);
        chk("reset cs_n0", cs_n0, 1'b1);
        chk("reset sclk0", sclk0, 1'b0);
        chk("reset mosi0", mosi0, 1'b0);
        chk("reset sclk1", sclk1, 1'b1);
        chk("reset cs_n1", cs_n1, 1'b1);
        rst = 1'b0;
        @(posedge clk); #1;

        frame0(1'b0, 4'hA, 20'hABCDE, 20'h0);
        frame0(1'b1, 4'h5, 20'h12345, 20'h5A5A5);
        frame0(1'b0, 4'h3, 20'h0F0F0, 20'h0);
        for (int i = 0; i < 5; i++) begin
            frame0(1'($urandom), 4'($urandom), 20'($urandom), 20'($urandom));
        end
        frame0(1'b1, 4'hC, 20'h0, 20'h8_0001);

        // Abort a read mid-frame; everything returns to reset values on the next edge.
        rw0 = 1'b1; addr0 = 4'h7; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst cs_n0", cs_n0, 1'b1);
        chk("rst sclk0", sclk0, 1'b0);
        chk("rst busy0", busy0, 1'b0);
        chk("rst rddata0", rddata0, 20'h0);
        chk("rst done0", done0, 1'b0);
        chk("rst rd_ok0", rd_ok0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_rd0 = '0;
        model_rd1 = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("no done after abort", done0, 1'b0);
        chk("idle after abort", busy0, 1'b0);

        frame1(1'b1, 7'h2A, 8'h00, 8'hC3);
        frame1(1'b0, 7'h55, 8'hA7, 8'h00);
        for (int i = 0; i < 4; i++) begin
            frame1(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
        end

`ifdef SPI_MASTER_CFG_LOOPBACK_EN
        loopback0 = 1'b1;
        s0_force  = 1'b1;
        frame0(1'b1, 4'h3, 20'hFFFFF, 20'h0);
        loopback0 = 1'b0;
        s0_force  = 1'b0;
        frame0(1'b1, 4'h9, 20'h0, 20'h3_C3C3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_master_cfg.md
# spi_master_cfg

Parametrised 4-wire SPI master that runs one addressed read or write frame per `start` pulse. Address width, data width, SCLK divider and SPI mode (CPOL/CPHA) are all parameters. It sits between register-access logic in the 50 MHz `clk` domain and an external or on-chip SPI slave. It is the generalised successor of the fixed 4-bit-address / 20-bit-data master.

## Interface
- `ADDR_W`, 4: address field width, 1..16.
- `DATA_W`, 20: data field width, 1..32.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles, ≥1.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; ignored while `busy`=1.
- `rw` in 1: 1 = read, 0 = write; captured with `start`.
- `addr` in ADDR_W: captured with `start`.
- `wrdata` in DATA_W: captured with `start` (don't-care for reads).
- `loopback` in 1: internal MOSI→MISO loop (only with the macro).
- `busy` out 1: frame in progress, including the inter-frame gap.
- `done` out 1: one-cycle pulse at the end of every frame.
- `rd_ok` out 1: one-cycle pulse coincident with `done`, reads only.
- `rddata` out DATA_W: last read result; held until the next read completes.
- `sclk` out 1: SPI clock.
- `cs_n` out 1: chip select, active low.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation
- Frame: `rw`, then `addr` MSB-first, then the data field MSB-first. `FRAME_LEN = 1+ADDR_W+DATA_W` (25 at defaults).
- Write: data field = captured `wrdata` on `mosi`.
- Read: `mosi`=0 during the data field; `miso` sampled into a shift register; `rddata` loaded from it at `done`.
- FSM:
  - IDLE –start→ SETUP
  - SETUP (CLK_DIV cycles) → SHIFT
  - SHIFT (2·CLK_DIV·FRAME_LEN cycles) → HOLD
  - HOLD (CLK_DIV cycles) → GAP
  - GAP (CLK_DIV cycles) → IDLE
- `cs_n`=0 in SETUP, SHIFT and HOLD; 1 otherwise.
- `sclk`=CPOL outside SHIFT; it toggles every CLK_DIV cycles inside SHIFT, giving FRAME_LEN full periods.
- CPHA=0: bit 0 is on `mosi` from SETUP entry; sample on each leading edge; shift on each trailing edge.
- CPHA=1: shift on the leading edge; sample on the trailing edge.
- The bit counter and divider counter clear on every state entry.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `rd_ok`=0, `rddata`=0.
  - `cs_n`=1, `sclk`=CPOL, `mosi`=0.
  - FSM in IDLE.
- `start` accepted in cycle T with `busy`=0. From T+1: `busy`=1 and `cs_n`=0.
- `done` at T+1+2·CLK_DIV+2·CLK_DIV·FRAME_LEN. That is T+209 at defaults.
  - `cs_n` returns to 1 in the same cycle.
  - For reads, `rd_ok` and the new `rddata` appear in the same cycle.
- `busy` falls CLK_DIV cycles after `done`, so a new `start` is accepted from that cycle.
- `start` while `busy`=1 is dropped; it is not queued, and captured fields are not disturbed.
- `start` and `done` in the same cycle: `start` is ignored, because `busy` is still 1 during GAP.
- `rst` mid-frame takes effect on the next edge:
  - `cs_n`=1, `sclk`=CPOL, no `done`/`rd_ok`.
  - `rddata` cleared to 0.
- Input changes on `addr`/`wrdata`/`rw` after capture have no effect on the frame in flight.

## Configuration
- `SPI_MASTER_CFG_LOOPBACK_EN` defined: the internal MISO is `loopback ? mosi : miso`. `loopback` is sampled only while `busy`=0 and held for the frame.
- Not defined: the internal MISO is always `miso`. The `loopback` port remains but is unused.

## Test plan
- Reset: hold `rst` 3 cycles mid-frame → next cycle `cs_n`=1, `sclk`=CPOL, `busy`=0, `rddata`=0, no `done`.
- Write, defaults (mode 0): `addr`=4'hA, `wrdata`=20'hABCDE, `rw`=0.
  - `mosi` on rising edges = 0,1010,1010_1011_1100_1101_1110.
  - `done` at T+209; `rd_ok` stays 0.
- Read, defaults: slave model returns 20'h5A5A5 on `miso` → `rd_ok` and `done` at T+209, `rddata`=20'h5A5A5, held through a following write.
- Modes: CPOL=1/CPHA=1, CLK_DIV=1, ADDR_W=7, DATA_W=8, read 8'hC3.
  - `sclk` idles high; `rddata`=8'hC3.
  - Latency = 1+2+2·16 = 35 cycles.
- Busy handling: `start` pulses at T+5 and at the `done` cycle → both ignored. `start` at `done`+CLK_DIV → accepted, `cs_n` low next cycle.
- Loopback (macro defined): `loopback`=1, read with `addr`=4'h3 → `rddata`=0, since `mosi` is driven 0 in the data field. A bench also sets `miso`=1 constant to prove it is ignored.
